// File: rtl/lf_pkg.sv
// Shared constants, op encoding and prefix-depth helper for the
// Ladner-Fischer add/sub pipeline.
package lf_pkg;

  localparam int DEFAULT_WIDTH = 64;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Number of prefix levels, log2(width); width is a power of two.
  function automatic int lf_levels(input int width);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < width) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/lf_prefix_level.sv
// One combinational Ladner-Fischer level: the upper half of every 2^LEVEL
// block combines with the top bit of that block's lower half.
module lf_prefix_level
  import lf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LEVEL = 1
) (
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] p_i,
  output logic [WIDTH-1:0] g_o,
  output logic [WIDTH-1:0] p_o
);

  localparam int HALF  = 1 << (LEVEL - 1);
  localparam int BLOCK = 2 * HALF;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if ((i % BLOCK) >= HALF) begin : g_node
      localparam int J = (i / BLOCK) * BLOCK + HALF - 1;
      assign g_o[i] = g_i[i] | (g_i[J] & p_i[i]);
      assign p_o[i] = p_i[i] & p_i[J];
    end else begin : g_pass
      assign g_o[i] = g_i[i];
      assign p_o[i] = p_i[i];
    end
  end

endmodule

// File: rtl/lf_addsub_pipe.sv
// Pipelined add/subtract on a Ladner-Fischer carry network: input register,
// g/p register, mid-prefix register, result register; one global enable.
module lf_addsub_pipe
  import lf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int L = lf_levels(WIDTH);
  localparam int H = L / 2;

  logic             adv;
  op_e              op;
  logic [2:0]       vld_pipe_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] a_q, b_q;
  logic             cin_q;
  logic [WIDTH-1:0] g1_q, p1_q;
  logic             c1_q;
  logic [WIDTH-1:0] gm_q, pm_q, pbit_q;
  logic             cm_q;

  logic [WIDTH-1:0] gl [0:L];
  logic [WIDTH-1:0] pl [0:L];

  logic [WIDTH:0]   carry_d;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, ovf_d, zero_d;
  logic             cout_q, ovf_q, zero_q;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign op       = op_e'(in_sub);

  // Valid bits and result flags: the only state that needs a reset value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (adv) begin
      vld_pipe_q  <= {vld_pipe_q[1:0], in_valid};
      out_valid_q <= vld_pipe_q[2];
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  // Datapath registers; bubble contents are don't-care.
  always_ff @(posedge clk) begin
    if (adv) begin
      if (in_valid) begin
        a_q   <= in_a;
        b_q   <= (op == OP_SUB) ? ~in_b : in_b;
        cin_q <= (op == OP_SUB) | in_cin;
      end
      g1_q   <= a_q & b_q;
      p1_q   <= a_q ^ b_q;
      c1_q   <= cin_q;
      gm_q   <= gl[H];
      pm_q   <= pl[H];
      pbit_q <= p1_q;
      cm_q   <= c1_q;
    end
  end

  assign gl[0] = g1_q;
  assign pl[0] = p1_q;

  // Levels 1..H run before the mid register, H+1..L after it.
  for (genvar k = 1; k <= L; k++) begin : g_lvl
    logic [WIDTH-1:0] gin, pin;
    if (k == H + 1) begin : g_from_reg
      assign gin = gm_q;
      assign pin = pm_q;
    end else begin : g_from_prev
      assign gin = gl[k-1];
      assign pin = pl[k-1];
    end
    lf_prefix_level #(
      .WIDTH (WIDTH),
      .LEVEL (k)
    ) u_lvl (
      .g_i (gin),
      .p_i (pin),
      .g_o (gl[k]),
      .p_o (pl[k])
    );
  end

  always_comb begin
    carry_d = {gl[L] | (pl[L] & {WIDTH{cm_q}}), cm_q};
    sum_d   = pbit_q ^ carry_d[WIDTH-1:0];
    cout_d  = carry_d[WIDTH];
    ovf_d   = carry_d[WIDTH] ^ carry_d[WIDTH-1];
    zero_d  = (sum_d == '0);
  end

  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule

// File: doc/lf_addsub_pipe.md
# lf_addsub_pipe

Pipelined WIDTH-bit two's-complement adder/subtractor built on a Ladner-Fischer parallel-prefix carry network. It accepts operand pairs through a valid/ready handshake and returns sum or difference plus flags three cycles later. Prefix levels are split across pipeline registers. It is the registered, flow-controlled arithmetic unit that consumes carry-network outputs, and it sits between operand sources and result sinks in the datapath.

## Interface
- WIDTH, 64, operand width; power of two, at least 8
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand pair offered
- in_ready  out  1  unit accepts this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_sub  in  1  0: A+B+in_cin; 1: A-B (B inverted, carry-in forced 1)
- in_cin  in  1  carry-in, used only when in_sub=0
- out_valid  out  1  result held
- out_ready  in  1  sink takes result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry out of MSB; for subtract, 1 means no borrow (A >= B unsigned)
- out_ovf  out  1  signed overflow: c[WIDTH] XOR c[WIDTH-1]
- out_zero  out  1  out_sum == 0

## Operation
- Stage 1 (input register): capture A, B' = in_sub ? ~in_b : in_b, and cin' = in_sub | in_cin. Compute bitwise g = A & B' and p = A ^ B'. Register g, p, cin', valid.
- Stage 2: Ladner-Fischer prefix levels 1..L/2, where L = log2(WIDTH). For WIDTH=64, these are levels 1-3. Register group (G,P) vectors, p, cin', valid.
- Stage 3: levels L/2+1..L. Then carries c[0]=cin' and c[i+1] = G[i:0] | (P[i:0] & cin'). Sum = p ^ c[WIDTH-1:0]. Flags are derived from c[WIDTH] and c[WIDTH-1]. Register into the out_* outputs.
- Combine operator at every prefix node: G = g_hi | (g_lo & p_hi), P = p_hi & p_lo.
- Level k pairs each bit in the upper half of every 2^k block with the top bit of that block's lower half. This is standard Ladner-Fischer sparse fan-out.
- Flow control is a single global enable: adv = !out_valid | out_ready. in_ready = adv.
- All three stages shift together when adv=1 and hold when adv=0.
- A bubble (stage valid=0) still shifts, and its data is don't-care.
- Arithmetic is modulo 2^WIDTH. out_cout and out_ovf report the discarded information.

## Timing
- Latency: a transfer accepted on edge N appears with out_valid=1 after edge N+3, assuming no stall.
- Throughput: one operation per cycle while out_ready=1.
- Reset (rst_n=0 at an edge): all stage valid bits, out_valid, out_sum, out_cout, out_ovf and out_zero clear to 0. in_ready=1 during the first cycle after reset.
- Reset mid-operation discards all in-flight operations with no partial output.
- Stall: when out_valid=1 and out_ready=0, in_ready=0 and every register holds. out_* stay stable until the edge where out_valid & out_ready.
- A simultaneous out handshake and in handshake in the same cycle is legal. The pipeline advances, and no operation is lost or duplicated.
- in_a, in_b, in_sub and in_cin are sampled only on an edge where in_valid & in_ready.
- in_ready is combinational from out_valid and out_ready. There is no combinational path from in_valid to any output.

## Structure
- The shared package lf_pkg holds:
  - the DEFAULT_WIDTH constant;
  - an op enum with OP_ADD=0 and OP_SUB=1;
  - a function giving the prefix level count, log2(WIDTH).
- Sub-module lf_prefix_level, parameterised by WIDTH and LEVEL. It is one combinational Ladner-Fischer level built from the combine operator.
- The top instantiates this sub-module L times in a generate loop, with the pipeline register inserted after instance L/2.

## Test plan
- Add, no stall: A=0x0000_0000_FFFF_FFFF, B=1, cin=0. Expect out_sum=0x0000_0001_0000_0000, cout=0, ovf=0, zero=0, out_valid exactly 3 cycles after acceptance.
- Full carry ripple: A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1. Expect sum=0, cout=1, zero=1, ovf=0.
- Subtract:
  - A=5, B=7 gives sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
  - A=0x8000_0000_0000_0000, B=1 gives sum=0x7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1.
- Backpressure: stream 6 back-to-back ops (i+i for i=1..6) with out_ready held 0 for cycles 4-7.
  - in_ready must drop while out_valid=1.
  - Outputs 2,4,6,8,10,12 emerge in order with no loss or duplication.
  - out_sum must stay stable during the stall.
- Reset mid-flight: accept 2 ops, assert rst_n=0 for one cycle. Expect out_valid=0 and all outputs 0 next cycle, and neither op emerges afterward.
- Random: 10k random (A, B, sub, cin) with random out_ready. Compare against a golden model: A ± B + cin, with flags from a (WIDTH+1)-bit result.
